// File: rtl/mul_div_iter.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide datapath.
// Define MUL_DIV_ITER_DIV_EN to build the divider; without it divide ops finish at once with result 0.
module mul_div_iter #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | retiring BPC multiplier / quotient bits per cycle
   // FIX   | sign correction and result select
   // DONE  | result valid, done pulse; may accept a new start
   localparam int STEPS = XLEN / BPC;
   localparam int CW    = $clog2(STEPS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         cnt;
   logic [2:0]            op_q;
   logic                  sa, sb;
   logic [XLEN-1:0]       opnd;
   logic [2*XLEN-1:0]     acc, acc_step, prod;
   logic [XLEN+BPC-1:0]   mul_sum;
   logic                  accept, special, a_signed, b_signed, sa_in, sb_in;
   logic [XLEN-1:0]       a_mag, b_mag, special_res, fix_res;
   logic                  last_step;
`ifdef MUL_DIV_ITER_DIV_EN
   // Stored remainder is always below the divisor; the shifted partial remainder is XLEN+1 bits.
   logic [XLEN-1:0]       rem, rem_step, div_r, div_q;
   logic [XLEN:0]         div_t, div_d;
`endif

   assign ready     = (state == S_IDLE) || (state == S_DONE);
   assign busy      = (state == S_RUN)  || (state == S_FIX);
   assign done      = (state == S_DONE);
   assign accept    = ready && start && !flush;
   assign last_step = (cnt == CW'(STEPS - 1));

   // MUL is treated as signed x signed; the low half is identical either way.
   assign a_signed = op[2] ? !op[0] : (op[1:0] != 2'b11);
   assign b_signed = op[2] ? !op[0] : !op[1];
   assign sa_in    = a_signed && a[XLEN-1];
   assign sb_in    = b_signed && b[XLEN-1];
   assign a_mag    = sa_in ? -a : a;
   assign b_mag    = sb_in ? -b : b;

   always_comb begin
      special     = 1'b0;
      special_res = '0;
`ifdef MUL_DIV_ITER_DIV_EN
      if (op[2]) begin
         if (b == '0) begin
            special     = 1'b1;
            special_res = op[1] ? a : '1;
         end else if (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
            special     = 1'b1;
            special_res = op[1] ? '0 : a;
         end
      end
`else
      special = op[2];
`endif
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = special ? S_DONE : S_RUN;
         S_RUN:   if (flush) state_nx = S_IDLE;
                  else if (last_step) state_nx = S_FIX;
         S_FIX:   state_nx = flush ? S_IDLE : S_DONE;
         S_DONE:  if (accept) state_nx = special ? S_DONE : S_RUN;
                  else state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // One RUN step: low half of acc holds the multiplier (or dividend/quotient) and shifts right/left.
   always_comb begin
      mul_sum = {{BPC{1'b0}}, acc[2*XLEN-1:XLEN]};
      for (int i = 0; i < BPC; i++) begin
         if (acc[i]) mul_sum = mul_sum + ({{BPC{1'b0}}, opnd} << i);
      end
      acc_step = {mul_sum, acc[XLEN-1:BPC]};
`ifdef MUL_DIV_ITER_DIV_EN
      div_r = rem;
      div_q = acc[XLEN-1:0];
      div_t = '0;
      div_d = '0;
      for (int i = 0; i < BPC; i++) begin
         div_t = {div_r, div_q[XLEN-1]};
         div_d = div_t - {1'b0, opnd};
         div_q = {div_q[XLEN-2:0], ~div_d[XLEN]};
         div_r = div_d[XLEN] ? div_t[XLEN-1:0] : div_d[XLEN-1:0];
      end
      rem_step = div_r;
      if (op_q[2]) acc_step = {acc[2*XLEN-1:XLEN], div_q};
`endif
   end

   always_comb begin
      prod    = (sa ^ sb) ? -acc : acc;
      fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MUL_DIV_ITER_DIV_EN
      if (op_q[2]) begin
         if (op_q[1]) fix_res = sa ? -rem : rem;
         else         fix_res = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      end
`else
      if (op_q[2]) fix_res = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         op_q   <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         result <= '0;
`ifdef MUL_DIV_ITER_DIV_EN
         rem    <= '0;
`endif
      end else if (accept) begin
         cnt  <= '0;
         op_q <= op;
         sa   <= sa_in;
         sb   <= sb_in;
         if (special) result <= special_res;
`ifdef MUL_DIV_ITER_DIV_EN
         rem <= '0;
         if (op[2]) begin
            opnd <= b_mag;
            acc  <= {{XLEN{1'b0}}, a_mag};
         end else begin
            opnd <= a_mag;
            acc  <= {{XLEN{1'b0}}, b_mag};
         end
`else
         opnd <= a_mag;
         acc  <= {{XLEN{1'b0}}, b_mag};
`endif
      end else if (state == S_RUN && !flush) begin
         if (!last_step) cnt <= cnt + 1'b1;
         acc <= acc_step;
`ifdef MUL_DIV_ITER_DIV_EN
         rem <= rem_step;
`endif
      end else if (state == S_FIX && !flush) begin
         result <= fix_res;
      end
   end

endmodule

// File: tb/tb_mul_div_iter.sv
// Directed bench for mul_div_iter: vector table plus control sequences (flush, reset, back-to-back).
module tb_mul_div_iter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start1, start4, flush;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        ready1, busy1, done1, ready4, busy4, done4;
   logic [31:0] result1, result4;

   int checks = 0;
   int failures = 0;

   mul_div_iter #(.XLEN(32), .BPC(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b), .flush(flush),
      .ready(ready1), .busy(busy1), .done(done1), .result(result1));

   mul_div_iter #(.XLEN(32), .BPC(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .flush(flush),
      .ready(ready4), .busy(busy4), .done(done4), .result(result4));

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic run_op(input bit use4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output int busy_cycles);
      int n;
      bit seen;
      @(negedge clk);
      op = o; a = x; b = y;
      if (use4) start4 = 1'b1; else start1 = 1'b1;
      n = 0; seen = 0; busy_cycles = 0;
      while (!seen && n < 200) begin
         @(posedge clk); n++;
         @(negedge clk);
         start1 = 1'b0; start4 = 1'b0;
         if (use4 ? busy4 : busy1) busy_cycles++;
         if (use4 ? done4 : done1) seen = 1;
      end
      lat = seen ? n : -1;
      res = use4 ? result4 : result1;
   endtask

   initial begin
      logic [31:0] res;
      int lat, bc, n, dones, first;

      vecs[0]  = '{"mul",        3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
      vecs[1]  = '{"mulh",       3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
      vecs[2]  = '{"mulhsu",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
      vecs[3]  = '{"mulhu",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      vecs[4]  = '{"mul_pos",    3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 34};
      vecs[5]  = '{"mulhu_pos",  3'b011, 32'h12345678, 32'h00000010, 32'h00000001, 34};
      vecs[6]  = '{"div",        3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
      vecs[7]  = '{"rem",        3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
      vecs[8]  = '{"divu",       3'b101, 32'd100,      32'd7,        32'd14,       34};
      vecs[9]  = '{"remu",       3'b111, 32'd100,      32'd7,        32'd2,        34};
      vecs[10] = '{"rem_negb",   3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34};
      vecs[11] = '{"divu_by0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[12] = '{"rem_by0",    3'b110, 32'd5,        32'd0,        32'd5,        1};
      vecs[13] = '{"div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[14] = '{"rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
`ifndef MUL_DIV_ITER_DIV_EN
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].op[2]) begin
            vecs[i].res = '0;
            vecs[i].lat = 1;
         end
      end
`endif

      reset = 1'b0; start1 = 1'b0; start4 = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready",  {31'b0, ready1}, 32'd1);
      chk("reset_busy",   {31'b0, busy1},  32'd0);
      chk("reset_done",   {31'b0, done1},  32'd0);
      chk("reset_result", result1,         32'd0);
      reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
         chk({vecs[i].name, "_result"}, res, vecs[i].res);
         chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
         if (i == 0) chk("mul_busy_cycles", bc, 32'd33);
      end

      run_op(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, bc);
      chk("bpc4_mulhu_result", res, 32'hFFFFFFFE);
      chk("bpc4_mulhu_latency", lat, 32'd10);

      // start pulsed mid-RUN is ignored
      @(negedge clk);
      op = 3'b000; a = 32'd3; b = 32'd5; start1 = 1'b1;
      dones = 0; first = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
         if (c == 5) begin
            op = 3'b011; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start1 = 1'b1;
         end
         if (done1) begin
            dones++;
            if (first < 0) first = c;
         end
      end
      chk("ignore_start_dones", dones, 32'd1);
      chk("ignore_start_latency", first, 32'd34);
      chk("ignore_start_result", result1, 32'd15);

      // flush at cycle 10
      op = 3'b000; a = 32'd2; b = 32'd2; start1 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", {31'b0, ready1}, 32'd1);
      chk("flush_busy",  {31'b0, busy1},  32'd0);
      dones = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done1) dones++;
      end
      chk("flush_no_done", dones, 32'd0);
      chk("flush_result_kept", result1, 32'd15);

      // reset at cycle 5 of a run
      op = 3'b000; a = 32'd6; b = 32'd7; start1 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrun_reset_ready",  {31'b0, ready1}, 32'd1);
      chk("midrun_reset_busy",   {31'b0, busy1},  32'd0);
      chk("midrun_reset_done",   {31'b0, done1},  32'd0);
      chk("midrun_reset_result", result1,         32'd0);
      reset = 1'b1;

      // back-to-back start from DONE
      op = 3'b000; a = 32'd3; b = 32'd5; start1 = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk); n++;
         @(negedge clk);
         start1 = 1'b0;
         if (done1) break;
      end
      chk("b2b_first_latency", n, 32'd34);
      chk("b2b_first_result", result1, 32'd15);
      op = 3'b011; a = 32'hFFFFFFFF; b = 32'd2; start1 = 1'b1;
      n = 0; lat = -1;
      while (n < 100) begin
         @(posedge clk); n++;
         @(negedge clk);
         start1 = 1'b0;
         if (done1) begin
            lat = n;
            break;
         end
      end
      chk("b2b_second_latency", lat, 32'd34);
      chk("b2b_second_result", result1, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_iter.md
# mul_div_iter

Iterative, parametrised RV32M execution unit: all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on one shared shift/add–subtract datapath.

- Sits beside the ALU in the execute stage.
- Stalls the core through `busy`.
- Returns the result to writeback through the `WB_MUL` path.
- Generalises the four-way `mul_op_t` decode to a 3-bit funct3 opcode, configurable width and configurable bits retired per cycle.

## Interface
- `XLEN`, 32: operand/result width; even, ≥ 8.
- `BPC`, 1: bits retired per RUN cycle; 1, 2 or 4; `XLEN % BPC == 0`. `STEPS = XLEN/BPC`.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: request; accepted only when `ready` = 1.
- `op` in 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` in XLEN: rs1 (multiplicand/dividend); sampled on the accept edge only.
- `b` in XLEN: rs2 (multiplier/divisor); sampled on the accept edge only.
- `flush` in 1: abort the operation in flight.
- `ready` out 1: high in IDLE and DONE.
- `busy` out 1: high in RUN and FIX.
- `done` out 1: one-cycle pulse, `result` valid.
- `result` out XLEN: registered; holds until the next `done`.

## Operation
States:
- **IDLE**
  - With `start`: latch `op`, sign flags and operand magnitudes (absolute values for signed ops; MULHSU takes only `a` as signed). Clear `cnt`.
  - Next state is RUN, or DONE directly for special cases.
- **RUN**
  - Multiply: shift-add of BPC multiplier bits per cycle into a 2·XLEN accumulator.
  - Divide: restoring division, BPC quotient bits per cycle.
  - `cnt` increments each cycle; at `cnt == STEPS-1` → FIX.
- **FIX**
  - Negate the product if the signs differ.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Select the low half (MUL), high half (MULH*), quotient or remainder into `result`.
  - → DONE.
- **DONE**
  - `done` = 1 for exactly one cycle.
  - With `start` → accept (back-to-back); otherwise → IDLE.

Special cases (division ops; resolved in IDLE, straight to DONE, no RUN):
- Divisor 0: quotient = all ones; remainder = `a`.
- DIV/REM with `a` = most-negative and `b` = −1: quotient = `a`; remainder = 0.

Boundary rules:
- `start` while `busy` is ignored; no queueing.
- `flush` in RUN/FIX → IDLE next edge, no `done`, `result` unchanged.
- `flush` in DONE: `done` still pulses.
- `flush` together with `start` in IDLE: start is ignored.
- Product arithmetic is exact at 2·XLEN bits; no truncation before FIX.
- Division: XLEN+1-bit partial remainder.
- `cnt` width is clog2(STEPS); it never wraps within an operation.

## Timing
- Reset (`reset` low at an edge) values: state IDLE, `ready` 1, `busy` 0, `done` 0, `result` 0, `cnt` 0. Reset overrides everything, including mid-RUN.
- Latency, start accepted at edge E:
  - Normal: `done` high in the cycle after edge E+STEPS+1, i.e. STEPS+2 cycles; 34 cycles at XLEN=32, BPC=1.
  - Special case: `done` the cycle after E (1 cycle).
- Throughput: one operation per STEPS+2 cycles when start is back-to-back from DONE.
- `busy` rises the cycle after accept and falls as DONE is entered.

## Configuration
- `MUL_DIV_ITER_DIV_EN` defined: divider datapath, special-case logic and ops 100–111 are compiled in.
- Not defined:
  - Divide ops are accepted and go straight to DONE (1 cycle) with `result` = 0.
  - No subtractor or partial-remainder register is synthesised.
  - Multiply behaviour and timing are unchanged.

## Test plan
XLEN=32, BPC=1 unless stated.
- MUL: a=7, b=0xFFFFFFFD → `result` 0xFFFFFFEB, `done` 34 cycles after accept, `busy` high for 33 cycles.
- MULH: 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU: a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE.
- BPC=4: same MULHU → same value, `done` at 10 cycles.
- DIV: a=−7, b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU: a=100, b=7 → 14. REMU with the same operands → 2.
- Special cases (each `done` after 1 cycle):
  - DIVU: a=5, b=0 → 0xFFFFFFFF.
  - REM: a=5, b=0 → 5.
  - DIV: a=0x80000000, b=0xFFFFFFFF → 0x80000000.
  - REM: a=0x80000000, b=0xFFFFFFFF → 0.
- Control:
  - `start` pulsed during RUN → ignored, single `done`.
  - `flush` at cycle 10 → no `done`, `result` keeps its previous value, `ready` = 1 next cycle.
  - `reset` low at cycle 5 → all outputs at reset values next cycle.
  - Back-to-back `start` in DONE → second `done` 34 cycles later.
